pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined CPU. It replaces the fixed 32-bit PC register with a block that owns the complete next-PC decision. That decision covers start-up sequencing, sequential increment, stall hold, branch redirect with capture while stalled, trap vectoring and halt. The IF stage uses pc_o as the instruction-memory address. Hazard detection drives PCWrite_i, EX drives the branch inputs, and the exception logic drives trap_i.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VEC, 0: PC value after reset (WIDTH bits).
- TRAP_VEC, 'h80: PC loaded on trap (WIDTH bits).
- INC, 4: sequential increment.
- ALIGN_BITS, 2: low PC bits that must be zero; 0 disables alignment checking.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  leave IDLE/HALT and begin fetching.
- PCWrite_i  in  1  1 = PC may advance; 0 = stall (hold).
- branch_i  in  1  redirect request, single-cycle pulse.
- branch_target_i  in  WIDTH  redirect address, valid with branch_i.
- trap_i  in  1  exception redirect, single-cycle pulse.
- halt_i  in  1  stop fetching.
- pc_o  out  WIDTH  current fetch address.
- pc_seq_o  out  WIDTH  pc_o + INC, combinational, mod 2^WIDTH.
- valid_o  out  1  1 only in RUN; pc_o is a real fetch.
- pending_o  out  1  branch captured during stall, not yet applied.
- misalign_o  out  1  one-cycle pulse: applied branch target had nonzero low ALIGN_BITS.

## Operation
- Reset values:
  - State = IDLE.
  - pc_o = RESET_VEC.
  - valid_o = 0, pending_o = 0, misalign_o = 0.
  - Pending target register = 0.
- **IDLE:** pc_o holds. When start_i = 1 at an edge, go to RUN; pc_o stays RESET_VEC, so RESET_VEC is the first fetch address. All other inputs are ignored.
- **RUN:** next pc_o is chosen in strict priority order:
  1. trap_i = 1: pc_o <= TRAP_VEC, regardless of PCWrite_i. Clears any pending branch.
  2. PCWrite_i = 1 and pending set: pc_o <= pending target. Clear pending. A live branch_i in the same cycle is discarded as wrong-path.
  3. PCWrite_i = 1 and branch_i: pc_o <= branch_target_i.
  4. PCWrite_i = 1: pc_o <= pc_o + INC, wrapping mod 2^WIDTH.
  5. PCWrite_i = 0: pc_o holds. If branch_i = 1 and nothing is pending, capture branch_target_i and set pending. If a branch is already pending, later branch_i is ignored (oldest wins).
- **Alignment:** a target applied in cases 2 or 3 is loaded with its low ALIGN_BITS forced to 0. If those bits were nonzero, misalign_o = 1 for the cycle following the load. The alignment check happens at apply time, not capture time.
- **Halt:** halt_i = 1 in RUN moves to HALT at that edge. The PC update selected above still occurs on that edge. Pending state is retained.
- **HALT:** pc_o holds, valid_o = 0. start_i returns to RUN. A pending branch is then applied at the first edge with PCWrite_i = 1. trap_i in HALT loads TRAP_VEC and clears pending, staying in HALT.
- start_i in RUN is ignored.
- halt_i and start_i together in HALT: halt wins (stay).

## Timing
- Registered outputs: pc_o, valid_o, pending_o, misalign_o.
- pc_seq_o is combinational from pc_o.
- Redirect latency is 1 cycle: a branch or trap sampled at edge n is visible on pc_o after edge n.
- A branch captured during a stall is applied at the first edge where PCWrite_i = 1. pending_o falls at that same edge.
- rst_i asserted mid-operation takes effect immediately, not clock-aligned, and forces all reset values. Release is synchronous to the next edge.
- Wrap-around: pc_o = 2^WIDTH − INC followed by a sequential step gives 0.

## Test plan
- **Reset and start:** reset, then start_i = 1 for one cycle with PCWrite_i = 1 → pc_o = 0, 0, 4, 8. valid_o = 0 in IDLE and rises after the start edge.
- **Stalled branch:** in RUN at pc 0x10, PCWrite_i = 0 for 3 cycles with branch_i = 1 / target 0x200 on the first cycle and branch_i = 1 / target 0x300 on the second.
  - pc_o holds 0x10 and pending_o = 1.
  - After PCWrite_i = 1, pc_o = 0x200, pending_o = 0, then 0x204.
- **Trap priority:** trap_i and branch_i (target 0x40) together while PCWrite_i = 0 and a branch is pending → pc_o = 0x80 and pending_o = 0.
- **Misalignment:** branch to 0x103 → pc_o = 0x100 and misalign_o pulses for 1 cycle. With ALIGN_BITS = 0, pc_o = 0x103 and no pulse.
- **Wrap:** WIDTH = 8, INC = 4, pc_o = 0xFC → next pc_o = 0x00.
- **Halt and reset:**
  - halt_i at pc 0x20 → pc_o steps to 0x24 and then holds, valid_o = 0.
  - start_i → pc_o resumes 0x28.
  - rst_i pulsed mid-cycle → pc_o = 0 immediately and state = IDLE.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the hazard/EX/exception logic and the PC generator.
// Handshake: none of these signals is a valid/ready pair. Every request is sampled at the
// rising clock edge, and every response is held until the next edge.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             PCWrite_i;
    logic             branch_i;
    logic [WIDTH-1:0] branch_target_i;
    logic             trap_i;
    logic             halt_i;
    logic [WIDTH-1:0] pc_o;
    logic [WIDTH-1:0] pc_seq_o;
    logic             valid_o;
    logic             pending_o;
    logic             misalign_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, PCWrite_i, branch_i, branch_target_i, trap_i, halt_i,
        input  pc_o, pc_seq_o, valid_o, pending_o, misalign_o, state_o
    );

    modport slave (
        input  start_i, PCWrite_i, branch_i, branch_target_i, trap_i, halt_i,
        output pc_o, pc_seq_o, valid_o, pending_o, misalign_o, state_o
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. It handles start-up, increment, stall hold,
// branch capture while stalled, trap vectoring and halt.
module pc_gen #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC   = 'h80,
    parameter int               INC        = 4,
    parameter int               ALIGN_BITS = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pc_gen_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_LOW = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_pending;
    logic [WIDTH-1:0] r_target;
    logic             r_misalign;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_next_pending;
    logic [WIDTH-1:0] w_next_target;
    logic             w_next_misalign;
    logic [WIDTH-1:0] w_apply_tgt;

    // Alignment is judged on whichever target is actually applied, not on the one captured.
    assign w_apply_tgt = r_pending ? r_target : bus.branch_target_i;

    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_pending  = r_pending;
        w_next_target   = r_target;
        w_next_misalign = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) w_next_state = RUN;
            end
            RUN: begin
                if (bus.trap_i) begin
                    w_next_pc      = TRAP_VEC;
                    w_next_pending = 1'b0;
                end else if (bus.PCWrite_i) begin
                    if (r_pending || bus.branch_i) begin
                        w_next_pc       = w_apply_tgt & ~ALIGN_LOW;
                        w_next_misalign = |(w_apply_tgt & ALIGN_LOW);
                        w_next_pending  = 1'b0;
                    end else begin
                        w_next_pc = r_pc + WIDTH'(INC);
                    end
                end else if (bus.branch_i && !r_pending) begin
                    w_next_pending = 1'b1;
                    w_next_target  = bus.branch_target_i;
                end
                if (bus.halt_i) w_next_state = HALT;
            end
            HALT: begin
                if (bus.trap_i) begin
                    w_next_pc      = TRAP_VEC;
                    w_next_pending = 1'b0;
                end
                if (bus.start_i && !bus.halt_i) w_next_state = RUN;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_pc       <= RESET_VEC;
            r_valid    <= 1'b0;
            r_pending  <= 1'b0;
            r_target   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_valid    <= (w_next_state == RUN);
            r_pending  <= w_next_pending;
            r_target   <= w_next_target;
            r_misalign <= w_next_misalign;
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_seq_o   = r_pc + WIDTH'(INC);
    assign bus.valid_o    = r_valid;
    assign bus.pending_o  = r_pending;
    assign bus.misalign_o = r_misalign;
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen. A behavioural model is checked against the DUT on every falling edge,
// and literal checks pin both the model and two extra configurations (no alignment, 8-bit wrap).
module tb_pc_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_gen_if #(.WIDTH(32)) bus   ();
    pc_gen_if #(.WIDTH(32)) bus_a ();
    pc_gen_if #(.WIDTH(8))  bus_w ();

    pc_gen #(.WIDTH(32)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
    pc_gen #(.WIDTH(32), .ALIGN_BITS(0)) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    pc_gen #(.WIDTH(8), .RESET_VEC(8'h00), .TRAP_VEC(8'h80)) u_dut_w (.clk_i(clk), .rst_i(rst), .bus(bus_w.slave));

    assign bus_a.start_i         = bus.start_i;
    assign bus_a.PCWrite_i       = bus.PCWrite_i;
    assign bus_a.branch_i        = bus.branch_i;
    assign bus_a.branch_target_i = bus.branch_target_i;
    assign bus_a.trap_i          = bus.trap_i;
    assign bus_a.halt_i          = bus.halt_i;
    assign bus_w.start_i         = bus.start_i;
    assign bus_w.PCWrite_i       = bus.PCWrite_i;
    assign bus_w.branch_i        = bus.branch_i;
    assign bus_w.branch_target_i = bus.branch_target_i[7:0];
    assign bus_w.trap_i          = bus.trap_i;
    assign bus_w.halt_i          = bus.halt_i;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural model of the main DUT: mode 0 = idle, 1 = running, 2 = halted
    int          m_mode;
    longint      m_pc;
    bit          m_pend;
    longint      m_tgt;
    bit          m_mis;

    function automatic longint aligned(input longint t);
        return (t / 4) * 4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pc = 0; m_pend = 0; m_tgt = 0; m_mis = 0;
        end else begin
            m_mis = 0;
            if (m_mode == 0) begin
                if (bus.start_i) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.trap_i) begin
                    m_pc = 'h80; m_pend = 0;
                end else if (bus.PCWrite_i && m_pend) begin
                    m_pc = aligned(m_tgt); m_mis = (m_tgt % 4) != 0; m_pend = 0;
                end else if (bus.PCWrite_i && bus.branch_i) begin
                    m_pc  = aligned(longint'(bus.branch_target_i));
                    m_mis = (bus.branch_target_i % 4) != 0;
                end else if (bus.PCWrite_i) begin
                    m_pc = (m_pc + 4) % (64'd1 << 32);
                end else if (bus.branch_i && !m_pend) begin
                    m_pend = 1; m_tgt = longint'(bus.branch_target_i);
                end
                if (bus.halt_i) m_mode = 2;
            end else begin
                if (bus.trap_i) begin
                    m_pc = 'h80; m_pend = 0;
                end
                if (bus.start_i && !bus.halt_i) m_mode = 1;
            end
        end
    end

    // scoreboard compare, every falling edge outside reset
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp("model_pc",       bus.pc_o,       32'(m_pc));
            cmp("model_pc_seq",   bus.pc_seq_o,   32'((m_pc + 4) % (64'd1 << 32)));
            cmp("model_valid",    {31'd0, bus.valid_o},    {31'd0, m_mode == 1});
            cmp("model_pending",  {31'd0, bus.pending_o},  {31'd0, m_pend});
            cmp("model_misalign", {31'd0, bus.misalign_o}, {31'd0, m_mis});
            cmp("model_state",    {30'd0, bus.state_o},    32'(m_mode));
        end
    end

    // driver
    task automatic step(input logic s, input logic p, input logic b, input logic [31:0] t,
                        input logic tr, input logic h);
        bus.start_i = s; bus.PCWrite_i = p; bus.branch_i = b;
        bus.branch_target_i = t; bus.trap_i = tr; bus.halt_i = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start_i = 0; bus.PCWrite_i = 0; bus.branch_i = 0;
        bus.branch_target_i = '0; bus.trap_i = 0; bus.halt_i = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp("rst_pc", bus.pc_o, 32'h0);
        cmp("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        cmp("rst_pending", {31'd0, bus.pending_o}, 32'd0);

        // reset and start: first fetch is RESET_VEC
        step(0, 1, 0, 0, 0, 0);
        cmp("idle_hold_pc", bus.pc_o, 32'h0);
        cmp("idle_valid", {31'd0, bus.valid_o}, 32'd0);
        step(1, 1, 0, 0, 0, 0);
        cmp("start_pc", bus.pc_o, 32'h0);
        cmp("start_valid", {31'd0, bus.valid_o}, 32'd1);
        step(0, 1, 0, 0, 0, 0);
        cmp("seq_pc_4", bus.pc_o, 32'h4);
        step(0, 1, 0, 0, 0, 0);
        cmp("seq_pc_8", bus.pc_o, 32'h8);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        cmp("seq_pc_10", bus.pc_o, 32'h10);

        // stalled branch capture, oldest wins
        step(0, 0, 1, 32'h200, 0, 0);
        cmp("stall_pc", bus.pc_o, 32'h10);
        cmp("stall_pending", {31'd0, bus.pending_o}, 32'd1);
        step(0, 0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        cmp("stall_pc_hold", bus.pc_o, 32'h10);
        step(0, 1, 1, 32'h600, 0, 0);
        cmp("pending_apply_pc", bus.pc_o, 32'h200);
        cmp("pending_apply_clr", {31'd0, bus.pending_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        cmp("after_apply_pc", bus.pc_o, 32'h204);

        // trap beats pending and live branch
        step(0, 0, 1, 32'h500, 0, 0);
        step(0, 0, 1, 32'h40, 1, 0);
        cmp("trap_pc", bus.pc_o, 32'h80);
        cmp("trap_pending", {31'd0, bus.pending_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        cmp("after_trap_pc", bus.pc_o, 32'h84);

        // misalignment on direct branch
        step(0, 1, 1, 32'h103, 0, 0);
        cmp("mis_pc", bus.pc_o, 32'h100);
        cmp("mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
        cmp("noalign_pc", bus_a.pc_o, 32'h103);
        cmp("noalign_pulse", {31'd0, bus_a.misalign_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        cmp("mis_pulse_end", {31'd0, bus.misalign_o}, 32'd0);
        cmp("mis_next_pc", bus.pc_o, 32'h104);

        // misalignment judged when a pending target is applied
        step(0, 0, 1, 32'h2A2, 0, 0);
        cmp("mis_capture_quiet", {31'd0, bus.misalign_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        cmp("mis_pend_pc", bus.pc_o, 32'h2A0);
        cmp("mis_pend_pulse", {31'd0, bus.misalign_o}, 32'd1);

        // halt steps once then holds; start resumes
        step(0, 1, 1, 32'h20, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        cmp("halt_pc", bus.pc_o, 32'h24);
        cmp("halt_valid", {31'd0, bus.valid_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        cmp("halt_hold", bus.pc_o, 32'h24);
        step(1, 1, 0, 0, 0, 1);
        cmp("halt_wins_state", {30'd0, bus.state_o}, 32'd2);
        step(1, 1, 0, 0, 0, 0);
        cmp("resume_valid", {31'd0, bus.valid_o}, 32'd1);
        step(0, 1, 0, 0, 0, 0);
        cmp("resume_pc", bus.pc_o, 32'h28);

        // pending retained across halt, applied after restart
        step(0, 0, 1, 32'h400, 0, 1);
        cmp("halt_pend", {31'd0, bus.pending_o}, 32'd1);
        step(1, 0, 0, 0, 0, 0);
        cmp("restart_pc", bus.pc_o, 32'h28);
        step(0, 1, 0, 0, 0, 0);
        cmp("restart_apply", bus.pc_o, 32'h400);

        // trap while halted
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        cmp("halt_trap_pc", bus.pc_o, 32'h80);
        cmp("halt_trap_state", {30'd0, bus.state_o}, 32'd2);

        // asynchronous reset mid-cycle
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 32'h700, 0, 0);
        #3 rst = 1'b1;
        #1;
        cmp("async_rst_pc", bus.pc_o, 32'h0);
        cmp("async_rst_state", {30'd0, bus.state_o}, 32'd0);
        cmp("async_rst_pending", {31'd0, bus.pending_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 0, 0, 0, 0);
        cmp("post_rst_idle", bus.pc_o, 32'h0);

        // 8-bit wrap-around
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'hFC, 0, 0);
        cmp("w8_pc_fc", {24'd0, bus_w.pc_o}, 32'hFC);
        cmp("w8_seq_wrap", {24'd0, bus_w.pc_seq_o}, 32'h0);
        step(0, 1, 0, 0, 0, 0);
        cmp("w8_wrap_pc", {24'd0, bus_w.pc_o}, 32'h0);
        cmp("main_no_wrap", bus.pc_o, 32'h100);

        step(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
